// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first,
// through a single FullSubtractor cell with a registered borrow.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
   logic [CW-1:0]    cnt;
   logic             brw, sa, sb;
   logic             d_bit, b_bit, last;
   logic             unused_lsb;

   FullSubtractor fs (
      .Xin  (a_sh[0]),
      .Yin  (b_sh[0]),
      .Bin  (brw),
      .Diff (d_bit),
      .Bout (b_bit)
   );

   // A 1-bit result register has nothing to shift down, only the new bit.
   generate
      if (WIDTH == 1) begin : g_res1
         assign res_nxt = d_bit;
      end else begin : g_resn
         assign res_nxt = {d_bit, res_sh[WIDTH-1:1]};
      end
   endgenerate

   assign unused_lsb = res_sh[0];
   assign last       = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         brw        <= 1'b0;
         cnt        <= '0;
         sa         <= 1'b0;
         sb         <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  res_sh <= '0;
                  brw    <= 1'b0;
                  cnt    <= '0;
                  sa     <= a[WIDTH-1];
                  sb     <= b[WIDTH-1];
                  busy   <= 1'b1;
               end
            end
            SHIFT: begin
               res_sh <= res_nxt;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               brw    <= b_bit;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  // The cell's Diff on the last bit is the result sign bit.
                  diff       <= res_nxt;
                  borrow_out <= b_bit;
                  zero       <= (res_nxt == '0);
                  overflow   <= (sa != sb) && (d_bit != sa);
                  done       <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// One-bit full subtractor: Diff = Xin - Yin - Bin, Bout set on underflow.
module FullSubtractor (
   input  logic Xin,
   input  logic Yin,
   input  logic Bin,
   output logic Diff,
   output logic Bout
);
   assign Diff = Xin ^ Yin ^ Bin;
   assign Bout = (~Xin & (Yin | Bin)) | (Yin & Bin);
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH = 1, 8 and 16.
module tb_serial_subtractor;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start1, start8, start16;
   logic [0:0]  a1, b1, diff1;
   logic [7:0]  a8, b8, diff8;
   logic [15:0] a16, b16, diff16;
   logic        busy1, done1, bo1, ov1, z1;
   logic        busy8, done8, bo8, ov8, z8;
   logic        busy16, done16, bo16, ov16, z16;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .busy(busy1), .done(done1),
      .diff(diff1), .borrow_out(bo1), .overflow(ov1), .zero(z1));
   serial_subtractor #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .busy(busy8), .done(done8),
      .diff(diff8), .borrow_out(bo8), .overflow(ov8), .zero(z8));
   serial_subtractor #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .busy(busy16), .done(done16),
      .diff(diff16), .borrow_out(bo16), .overflow(ov16), .zero(z16));

   typedef struct {
      int          w;
      logic [31:0] x, y, d;
      logic        eb, eo, ez;
   } vec_t;

   // {busy, done, borrow_out, overflow, zero, diff[31:0]}
   function automatic logic [36:0] obs(input int w);
      case (w)
         1:       obs = {busy1, done1, bo1, ov1, z1, 31'b0, diff1};
         8:       obs = {busy8, done8, bo8, ov8, z8, 24'b0, diff8};
         default: obs = {busy16, done16, bo16, ov16, z16, 16'b0, diff16};
      endcase
   endfunction

   task automatic drive(input int w, input logic s, input logic [31:0] x, input logic [31:0] y);
      case (w)
         1:       begin start1  = s; a1  = x[0];    b1  = y[0];    end
         8:       begin start8  = s; a8  = x[7:0];  b8  = y[7:0];  end
         default: begin start16 = s; a16 = x[15:0]; b16 = y[15:0]; end
      endcase
   endtask

   // Called on a falling edge; returns on the falling edge where done is seen.
   task automatic run_op(input int w, input logic [31:0] x, input logic [31:0] y,
                         output int nb, output int cyc, output logic [36:0] o);
      drive(w, 1'b1, x, y);
      @(negedge clk);
      drive(w, 1'b0, 32'h0, 32'h0);
      nb  = 0;
      cyc = 1;
      o   = obs(w);
      while (!o[35] && cyc < 80) begin
         if (o[36]) nb++;
         @(negedge clk);
         cyc++;
         o = obs(w);
      end
   endtask

   task automatic test_reset;
      logic [36:0] o;
      rst = 1'b1;
      drive(1, 1'b0, 32'h0, 32'h0);
      drive(8, 1'b0, 32'h0, 32'h0);
      drive(16, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      foreach (u_w[i]) begin
         o = obs(u_w[i]);
         checks++;
         if (o !== 37'h0) begin
            errors++;
            $display("FAIL reset_w%0d: got %h expected 0", u_w[i], o);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   int u_w[3] = '{1, 8, 16};

   task automatic test_arith;
      vec_t        tbl[13];
      int          nb, cyc;
      logic [36:0] o;
      tbl = '{
         '{8,  32'd100,   32'd37,    32'd63,    1'b0, 1'b0, 1'b0},
         '{8,  32'd5,     32'd9,     32'hFC,    1'b1, 1'b0, 1'b0},
         '{8,  32'h80,    32'h01,    32'h7F,    1'b0, 1'b1, 1'b0},
         '{8,  32'h7F,    32'hFF,    32'h80,    1'b1, 1'b1, 1'b0},
         '{8,  32'hA5,    32'hA5,    32'h00,    1'b0, 1'b0, 1'b1},
         '{1,  32'd1,     32'd0,     32'd1,     1'b0, 1'b0, 1'b0},
         '{1,  32'd0,     32'd1,     32'd1,     1'b1, 1'b1, 1'b0},
         '{1,  32'd1,     32'd1,     32'd0,     1'b0, 1'b0, 1'b1},
         '{1,  32'd0,     32'd0,     32'd0,     1'b0, 1'b0, 1'b1},
         '{16, 32'h0000,  32'h0001,  32'hFFFF,  1'b1, 1'b0, 1'b0},
         '{16, 32'h8000,  32'h0001,  32'h7FFF,  1'b0, 1'b1, 1'b0},
         '{16, 32'h7FFF,  32'hFFFF,  32'h8000,  1'b1, 1'b1, 1'b0},
         '{16, 32'h1234,  32'h1234,  32'h0000,  1'b0, 1'b0, 1'b1}
      };
      foreach (tbl[i]) begin
         run_op(tbl[i].w, tbl[i].x, tbl[i].y, nb, cyc, o);
         checks++;
         if (!o[35] || nb != tbl[i].w || cyc != tbl[i].w + 1) begin
            errors++;
            $display("FAIL timing_%0d: done=%b busy_cycles=%0d latency=%0d expected busy_cycles=%0d latency=%0d",
                     i, o[35], nb, cyc, tbl[i].w, tbl[i].w + 1);
         end
         checks++;
         if (o[31:0] !== tbl[i].d) begin
            errors++;
            $display("FAIL diff_%0d: got %h expected %h", i, o[31:0], tbl[i].d);
         end
         checks++;
         if (o[34:32] !== {tbl[i].eb, tbl[i].eo, tbl[i].ez}) begin
            errors++;
            $display("FAIL flags_%0d: got bo/ov/z=%b expected %b", i, o[34:32],
                     {tbl[i].eb, tbl[i].eo, tbl[i].ez});
         end
      end
   endtask

   task automatic test_ignore_start;
      int          cyc;
      logic [36:0] o;
      drive(8, 1'b1, 32'd200, 32'd1);
      @(negedge clk);
      drive(8, 1'b0, 32'h0, 32'h0);
      cyc = 1;
      @(negedge clk); cyc++;
      @(negedge clk); cyc++;
      drive(8, 1'b1, 32'd0, 32'd0);
      @(negedge clk); cyc++;
      drive(8, 1'b0, 32'h0, 32'h0);
      o = obs(8);
      while (!o[35] && cyc < 80) begin
         @(negedge clk);
         cyc++;
         o = obs(8);
      end
      checks++;
      if (!o[35] || cyc != 9) begin
         errors++;
         $display("FAIL ignore_timing: done=%b latency=%0d expected latency=9", o[35], cyc);
      end
      checks++;
      if (o[31:0] !== 32'd199 || o[34:32] !== 3'b000) begin
         errors++;
         $display("FAIL ignore_result: got diff=%0d flags=%b expected diff=199 flags=000",
                  o[31:0], o[34:32]);
      end
   endtask

   task automatic test_reset_mid;
      logic [36:0] o;
      logic        seen;
      drive(8, 1'b1, 32'd50, 32'd3);
      @(negedge clk);
      drive(8, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      o = obs(8);
      checks++;
      if (o !== 37'h0) begin
         errors++;
         $display("FAIL reset_mid: got %h expected 0", o);
      end
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_mid_quiet: got busy/done activity expected none");
      end
   endtask

   task automatic test_back_to_back;
      int          nb, cyc;
      logic [36:0] o;
      run_op(8, 32'd20, 32'd7, nb, cyc, o);
      checks++;
      if (o[31:0] !== 32'd13) begin
         errors++;
         $display("FAIL b2b_first: got %h expected %h", o[31:0], 32'd13);
      end
      // Next start is driven in the done cycle itself.
      run_op(8, 32'h10, 32'h03, nb, cyc, o);
      checks++;
      if (!o[35] || nb != 8 || cyc != 9 || o[31:0] !== 32'h0D) begin
         errors++;
         $display("FAIL b2b_second: done=%b busy_cycles=%0d latency=%0d diff=%h expected 1/8/9/0d",
                  o[35], nb, cyc, o[31:0]);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || diff8 !== 8'h0D) begin
         errors++;
         $display("FAIL done_pulse: got done=%b diff=%h expected done=0 diff=0d", done8, diff8);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
